// File: rtl/ahbl_mtimer.sv
// AHB-Lite machine timer: 64-bit mtime with prescaler, mtimecmp, msip, and a
// two-cycle ERROR response for any non-word transfer.
module ahbl_mtimer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ahbls_hready,
  output logic        ahbls_hready_resp,
  output logic        ahbls_hresp,
  input  logic [31:0] ahbls_haddr,
  input  logic        ahbls_hwrite,
  input  logic [1:0]  ahbls_htrans,
  input  logic [2:0]  ahbls_hsize,
  input  logic [31:0] ahbls_hwdata,
  output logic [31:0] ahbls_hrdata,
  output logic        soft_irq,
  output logic        timer_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_MSIP   = 3'd1;
  localparam logic [2:0] A_MT_LO  = 3'd2;
  localparam logic [2:0] A_MT_HI  = 3'd3;
  localparam logic [2:0] A_CMP_LO = 3'd4;
  localparam logic [2:0] A_CMP_HI = 3'd5;
  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 32'd1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [2:0]  r_dp_addr;
  logic        r_en;
  logic        r_msip;
  logic [7:0]  r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow;
  logic        r_timer_irq;

  logic        w_accept;
  logic        w_size_err;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_size_err = (ahbls_hsize != 3'd2);
  // ERR1 stalls the bus, so no address phase can be taken there.
  assign w_accept   = ahbls_hready && ahbls_htrans[1] && (r_state != ST_ERR1);
  assign w_wr       = r_dp_valid && r_dp_write;
  assign w_rd       = r_dp_valid && !r_dp_write;
  assign w_tick     = r_en && (r_presc == PRESC_MAX);
  assign w_unused   = ^{ahbls_haddr[31:5], ahbls_haddr[1:0], ahbls_htrans[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = (w_accept && w_size_err) ? ST_ERR1 : ST_IDLE;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = (w_accept && w_size_err) ? ST_ERR1 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (r_state)
      ST_IDLE: begin ahbls_hready_resp = 1'b1; ahbls_hresp = 1'b0; end
      ST_ERR1: begin ahbls_hready_resp = 1'b0; ahbls_hresp = 1'b1; end
      ST_ERR2: begin ahbls_hready_resp = 1'b1; ahbls_hresp = 1'b1; end
      default: begin ahbls_hready_resp = 1'b1; ahbls_hresp = 1'b0; end
    endcase
  end

  // Errored transfers never open a data phase, so they have no side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 3'd0;
    end else begin
      r_dp_valid <= w_accept && !w_size_err;
      if (w_accept) begin
        r_dp_write <= ahbls_hwrite;
        r_dp_addr  <= ahbls_haddr[4:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b1;
      r_msip <= 1'b0;
    end else if (w_wr && (r_dp_addr == A_CTRL)) begin
      r_en <= ahbls_hwdata[0];
    end else if (w_wr && (r_dp_addr == A_MSIP)) begin
      r_msip <= ahbls_hwdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
    end else if (w_wr && (r_dp_addr == A_CTRL)) begin
      r_presc <= 8'd0;
    end else if (r_en) begin
      r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
    end
  end

  // A bus write to either half beats a coincident increment; the other half holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= 64'd0;
    end else if (w_wr && (r_dp_addr == A_MT_LO)) begin
      r_mtime[31:0] <= ahbls_hwdata;
    end else if (w_wr && (r_dp_addr == A_MT_HI)) begin
      r_mtime[63:32] <= ahbls_hwdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 32'd0;
    end else if (w_wr && (r_dp_addr == A_MT_HI)) begin
      r_shadow <= ahbls_hwdata;
    end else if (w_rd && (r_dp_addr == A_MT_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (w_wr && (r_dp_addr == A_CMP_LO)) begin
      r_mtimecmp[31:0] <= ahbls_hwdata;
    end else if (w_wr && (r_dp_addr == A_CMP_HI)) begin
      r_mtimecmp[63:32] <= ahbls_hwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_irq <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (r_dp_addr)
        A_CTRL:   w_rdata = {31'd0, r_en};
        A_MSIP:   w_rdata = {31'd0, r_msip};
        A_MT_LO:  w_rdata = r_mtime[31:0];
        A_MT_HI:  w_rdata = r_shadow;
        A_CMP_LO: w_rdata = r_mtimecmp[31:0];
        A_CMP_HI: w_rdata = r_mtimecmp[63:32];
        default:  w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign ahbls_hrdata = w_rdata;
  assign soft_irq     = r_msip;
  assign timer_irq    = r_timer_irq;

endmodule

// File: tb/tb_ahbl_mtimer.sv
// Bench for ahbl_mtimer: two instances (TICK_DIV=4 and 1) share one bus and
// are checked against a cycle-level arithmetic model of the register file.
module tb_ahbl_mtimer;

  localparam logic [2:0] R_CTRL = 3'd0;
  localparam logic [2:0] R_MSIP = 3'd1;
  localparam logic [2:0] R_LO   = 3'd2;
  localparam logic [2:0] R_HI   = 3'd3;
  localparam logic [2:0] R_CLO  = 3'd4;
  localparam logic [2:0] R_CHI  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hready;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hrdy_q  [2];
  logic        hresp_q [2];
  logic        sirq_q  [2];
  logic        tirq_q  [2];
  logic [31:0] rdata_q [2];

  int total = 0;
  int bad   = 0;

  logic [63:0] m_mtime  [2];
  int          m_pcnt   [2];
  logic [31:0] m_shadow [2];
  logic        m_tirq   [2];
  int          m_div    [2] = '{4, 1};
  logic        m_en;
  logic        m_msip;
  logic [63:0] m_cmp;
  bit          p_wr;
  logic [2:0]  p_a;
  logic [31:0] p_d;
  bit          p_rdlo;

  always #5 clk = ~clk;

  ahbl_mtimer #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready),
    .ahbls_hready_resp(hrdy_q[0]), .ahbls_hresp(hresp_q[0]),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata_q[0]),
    .soft_irq(sirq_q[0]), .timer_irq(tirq_q[0])
  );

  ahbl_mtimer #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready),
    .ahbls_hready_resp(hrdy_q[1]), .ahbls_hresp(hresp_q[1]),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata_q[1]),
    .soft_irq(sirq_q[1]), .timer_irq(tirq_q[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mtime[k] = 64'd0; m_pcnt[k] = 0; m_shadow[k] = 32'd0; m_tirq[k] = 1'b0;
    end
    m_en = 1'b1; m_msip = 1'b0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    p_wr = 1'b0; p_rdlo = 1'b0;
  endtask

  // Advance one clock; the model applies the same edge, then outputs settle.
  task automatic step();
    logic [63:0] nm;
    int          np;
    logic        tk;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      tk = m_en && (m_pcnt[k] == m_div[k] - 1);
      nm = tk ? m_mtime[k] + 64'd1 : m_mtime[k];
      np = !m_en ? m_pcnt[k] : (tk ? 0 : m_pcnt[k] + 1);
      if (p_rdlo) m_shadow[k] = m_mtime[k][63:32];
      if (p_wr) begin
        case (p_a)
          R_CTRL: np = 0;
          R_LO:   nm = {m_mtime[k][63:32], p_d};
          R_HI:   begin nm = {p_d, m_mtime[k][31:0]}; m_shadow[k] = p_d; end
          default: ;
        endcase
      end
      m_tirq[k]  = (m_mtime[k] >= m_cmp);
      m_mtime[k] = nm;
      m_pcnt[k]  = np;
    end
    if (p_wr) begin
      case (p_a)
        R_CTRL: m_en = p_d[0];
        R_MSIP: m_msip = p_d[0];
        R_CLO:  m_cmp[31:0] = p_d;
        R_CHI:  m_cmp[63:32] = p_d;
        default: ;
      endcase
    end
    #1;
  endtask

  function automatic logic [31:0] model_rd(input int k, input logic [2:0] a);
    case (a)
      R_CTRL:  return {31'd0, m_en};
      R_MSIP:  return {31'd0, m_msip};
      R_LO:    return m_mtime[k][31:0];
      R_HI:    return m_shadow[k];
      R_CLO:   return m_cmp[31:0];
      R_CHI:   return m_cmp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_bus();
    hready = 1'b1; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    haddr = 32'd0; hwdata = 32'd0;
  endtask

  task automatic addr_phase(input logic [2:0] a, input logic wr, input logic [2:0] sz);
    haddr = {27'd0, a, 2'b00}; hwrite = wr; htrans = 2'b10; hsize = sz; hready = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1, 3'd2);
    step();
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    p_wr = 1'b1; p_a = a; p_d = d;
    step();
    p_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] act0, output logic [31:0] act1,
                          output logic [31:0] exp0, output logic [31:0] exp1);
    addr_phase(a, 1'b0, 3'd2);
    step();
    htrans = 2'b00;
    act0 = rdata_q[0]; act1 = rdata_q[1];
    exp0 = model_rd(0, a); exp1 = model_rd(1, a);
    p_rdlo = (a == R_LO);
    step();
    p_rdlo = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total += 4;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b0) begin bad++; $display("FAIL rst_resp[%0d] got=%b/%b exp=1/0", k, hrdy_q[k], hresp_q[k]); end
      if (rdata_q[k] !== 32'd0) begin bad++; $display("FAIL rst_rdata[%0d] got=%h exp=0", k, rdata_q[k]); end
      if (sirq_q[k] !== 1'b0) begin bad++; $display("FAIL rst_sirq[%0d] got=%b exp=0", k, sirq_q[k]); end
      if (tirq_q[k] !== 1'b0) begin bad++; $display("FAIL rst_tirq[%0d] got=%b exp=0", k, tirq_q[k]); end
    end
    rst_n = 1'b1;
    model_reset();
    step();
    for (int k = 0; k < 2; k++) begin
      total += 3;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b0) begin bad++; $display("FAIL rel_resp[%0d] got=%b/%b exp=1/0", k, hrdy_q[k], hresp_q[k]); end
      if (sirq_q[k] !== 1'b0 || tirq_q[k] !== 1'b0) begin bad++; $display("FAIL rel_irq[%0d] got=%b/%b exp=0/0", k, sirq_q[k], tirq_q[k]); end
      if (rdata_q[k] !== 32'd0) begin bad++; $display("FAIL rel_rdata[%0d] got=%h exp=0", k, rdata_q[k]); end
    end
  endtask

  task automatic test_tick_div();
    logic [31:0] a0, a1, e0, e1;
    repeat (39) step();
    bus_read(R_LO, a0, a1, e0, e1);
    total += 3;
    if (a0 < 32'd9 || a0 > 32'd11) begin bad++; $display("FAIL div4_40cyc got=%0d exp=10+-1", a0); end
    if (a0 !== e0) begin bad++; $display("FAIL div4_model got=%0d exp=%0d", a0, e0); end
    if (a1 !== e1) begin bad++; $display("FAIL div1_model got=%0d exp=%0d", a1, e1); end
    for (int r = 0; r < 8; r++) begin
      if (r == 2 || r == 3) continue;
      bus_read(3'(r), a0, a1, e0, e1);
      total++;
      if (a0 !== e0 || a1 !== e1) begin bad++; $display("FAIL rst_reg%0d got=%h/%h exp=%h/%h", r, a0, a1, e0, e1); end
    end
  endtask

  task automatic test_msip();
    logic [31:0] a0, a1, e0, e1;
    bus_write(R_MSIP, 32'd1);
    total++;
    if (sirq_q[0] !== 1'b1 || sirq_q[1] !== 1'b1) begin bad++; $display("FAIL msip_set got=%b%b exp=11", sirq_q[0], sirq_q[1]); end
    bus_write(R_MSIP, 32'd0);
    total++;
    if (sirq_q[0] !== 1'b0 || sirq_q[1] !== 1'b0) begin bad++; $display("FAIL msip_clr got=%b%b exp=00", sirq_q[0], sirq_q[1]); end
    bus_write(R_MSIP, 32'hFFFF_FFFE);
    total++;
    if (sirq_q[0] !== 1'b0 || sirq_q[1] !== 1'b0) begin bad++; $display("FAIL msip_rsvd got=%b%b exp=00", sirq_q[0], sirq_q[1]); end
    bus_read(R_MSIP, a0, a1, e0, e1);
    total++;
    if (a0 !== 32'd0 || a1 !== 32'd0) begin bad++; $display("FAIL msip_rd got=%h/%h exp=0", a0, a1); end
    bus_write(R_CTRL, 32'hFFFF_FFFF);
    bus_read(R_CTRL, a0, a1, e0, e1);
    total++;
    if (a0 !== 32'd1 || a1 !== 32'd1) begin bad++; $display("FAIL ctrl_rsvd got=%h/%h exp=1", a0, a1); end
  endtask

  task automatic test_carry();
    logic [31:0] l0, l1, h0, h1, el0, el1, eh0, eh1;
    bus_write(R_HI, 32'd0);
    bus_write(R_LO, 32'hFFFF_FFFE);
    repeat (3) step();
    bus_read(R_LO, l0, l1, el0, el1);
    bus_read(R_HI, h0, h1, eh0, eh1);
    total += 4;
    if (h1 !== 32'd1) begin bad++; $display("FAIL carry_hi got=%h exp=1", h1); end
    if (l1 > 32'd15) begin bad++; $display("FAIL carry_lo got=%h exp=small", l1); end
    if (l1 !== el1 || h1 !== eh1) begin bad++; $display("FAIL carry_pair1 got=%h_%h exp=%h_%h", h1, l1, eh1, el1); end
    if (l0 !== el0 || h0 !== eh0) begin bad++; $display("FAIL carry_pair0 got=%h_%h exp=%h_%h", h0, l0, eh0, el0); end
  endtask

  task automatic test_timer_irq();
    int reach = -1;
    int rise  = -1;
    bus_write(R_CTRL, 32'd0);
    bus_write(R_HI, 32'd0);
    bus_write(R_LO, 32'd0);
    bus_write(R_CHI, 32'd0);
    bus_write(R_CLO, 32'd20);
    bus_write(R_CTRL, 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (reach < 0 && m_mtime[1] == 64'd20) reach = i;
      if (rise < 0 && tirq_q[1] === 1'b1) rise = i;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (tirq_q[k] !== m_tirq[k]) begin bad++; $display("FAIL tirq_cyc[%0d] i=%0d got=%b exp=%b", k, i, tirq_q[k], m_tirq[k]); end
      end
    end
    total++;
    if (reach < 0 || rise != reach + 1) begin bad++; $display("FAIL tirq_latency rise=%0d exp=%0d", rise, reach + 1); end
    bus_write(R_CHI, 32'd1);
    step();
    total += 2;
    if (tirq_q[1] !== 1'b0) begin bad++; $display("FAIL tirq_deassert got=%b exp=0", tirq_q[1]); end
    if (tirq_q[0] !== m_tirq[0]) begin bad++; $display("FAIL tirq_deassert0 got=%b exp=%b", tirq_q[0], m_tirq[0]); end
  endtask

  task automatic test_error();
    logic [31:0] e;
    addr_phase(R_LO, 1'b1, 3'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (hrdy_q[k] !== 1'b0 || hresp_q[k] !== 1'b1 || rdata_q[k] !== 32'd0) begin
        bad++; $display("FAIL err1[%0d] got=%b/%b/%h exp=0/1/0", k, hrdy_q[k], hresp_q[k], rdata_q[k]);
      end
    end
    htrans = 2'b00; hwrite = 1'b0; hready = 1'b0; hwdata = $urandom;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b1) begin bad++; $display("FAIL err2[%0d] got=%b/%b exp=1/1", k, hrdy_q[k], hresp_q[k]); end
    end
    addr_phase(R_LO, 1'b0, 3'd2);
    step();
    htrans = 2'b00;
    for (int k = 0; k < 2; k++) begin
      e = model_rd(k, R_LO);
      total++;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b0 || rdata_q[k] !== e) begin
        bad++; $display("FAIL err_b2b[%0d] got=%b/%b/%h exp=1/0/%h", k, hrdy_q[k], hresp_q[k], rdata_q[k], e);
      end
    end
    p_rdlo = 1'b1;
    step();
    p_rdlo = 1'b0;
    addr_phase(R_CLO, 1'b1, 3'd1);
    step();
    htrans = 2'b00; hready = 1'b0; hwdata = 32'd7;
    step();
    hready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b0 || rdata_q[k] !== 32'd0) begin
        bad++; $display("FAIL err_idle[%0d] got=%b/%b/%h exp=1/0/0", k, hrdy_q[k], hresp_q[k], rdata_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e;
    d = $urandom;
    addr_phase(R_CLO, 1'b1, 3'd2);
    step();
    hwdata = d; p_wr = 1'b1; p_a = R_CLO; p_d = d;
    addr_phase(R_CLO, 1'b0, 3'd2);
    step();
    p_wr = 1'b0;
    addr_phase(R_HI, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rdata_q[k] !== d) begin bad++; $display("FAIL b2b_wr_rd[%0d] got=%h exp=%h", k, rdata_q[k], d); end
    end
    step();
    addr_phase(R_LO, 1'b0, 3'd2);
    step();
    addr_phase(R_HI, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      e = model_rd(k, R_LO);
      total++;
      if (rdata_q[k] !== e) begin bad++; $display("FAIL b2b_lo[%0d] got=%h exp=%h", k, rdata_q[k], e); end
    end
    p_rdlo = 1'b1;
    step();
    p_rdlo = 1'b0;
    htrans = 2'b00;
    for (int k = 0; k < 2; k++) begin
      e = model_rd(k, R_HI);
      total++;
      if (rdata_q[k] !== e) begin bad++; $display("FAIL b2b_hi[%0d] got=%h exp=%h", k, rdata_q[k], e); end
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a0, a1, e0, e1, d;
    logic [2:0]  a;
    for (int it = 0; it < 60; it++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: bus_write(a, d);
        1: begin
          bus_read(a, a0, a1, e0, e1);
          total++;
          if (a0 !== e0 || a1 !== e1) begin bad++; $display("FAIL rnd_rd it=%0d a=%0d got=%h/%h exp=%h/%h", it, a, a0, a1, e0, e1); end
        end
        default: repeat ($urandom_range(1, 5)) step();
      endcase
      for (int k = 0; k < 2; k++) begin
        total++;
        if (sirq_q[k] !== m_msip || tirq_q[k] !== m_tirq[k]) begin
          bad++; $display("FAIL rnd_irq[%0d] it=%0d got=%b/%b exp=%b/%b", k, it, sirq_q[k], tirq_q[k], m_msip, m_tirq[k]);
        end
      end
    end
    bus_write(R_CTRL, 32'd1);
  endtask

  task automatic test_reset_err1();
    logic [31:0] a0, a1, e0, e1;
    bus_write(R_CHI, 32'd0);
    bus_write(R_CLO, 32'd0);
    step();
    total++;
    if (tirq_q[0] !== 1'b1 || tirq_q[1] !== 1'b1) begin bad++; $display("FAIL pre_rst_tirq got=%b%b exp=11", tirq_q[0], tirq_q[1]); end
    addr_phase(R_LO, 1'b1, 3'd0);
    step();
    total++;
    if (hrdy_q[0] !== 1'b0 || hrdy_q[1] !== 1'b0) begin bad++; $display("FAIL rst_err1_entry got=%b%b exp=00", hrdy_q[0], hrdy_q[1]); end
    htrans = 2'b00; hready = 1'b0; hwdata = $urandom;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (hrdy_q[k] !== 1'b1 || hresp_q[k] !== 1'b0 || tirq_q[k] !== 1'b0 || rdata_q[k] !== 32'd0) begin
        bad++; $display("FAIL rst_err1[%0d] got=%b/%b/%b/%h exp=1/0/0/0", k, hrdy_q[k], hresp_q[k], tirq_q[k], rdata_q[k]);
      end
    end
    @(posedge clk);
    #1;
    idle_bus();
    rst_n = 1'b1;
    model_reset();
    bus_read(R_CLO, a0, a1, e0, e1);
    total++;
    if (a0 !== 32'hFFFF_FFFF || a1 !== 32'hFFFF_FFFF || a0 !== e0) begin bad++; $display("FAIL rst_cmp_lo got=%h/%h exp=ffffffff", a0, a1); end
    bus_read(R_CHI, a0, a1, e0, e1);
    total++;
    if (a0 !== 32'hFFFF_FFFF || a1 !== 32'hFFFF_FFFF || a1 !== e1) begin bad++; $display("FAIL rst_cmp_hi got=%h/%h exp=ffffffff", a0, a1); end
    total++;
    if (tirq_q[0] !== 1'b0 || tirq_q[1] !== 1'b0) begin bad++; $display("FAIL rst_tirq_after got=%b%b exp=00", tirq_q[0], tirq_q[1]); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    model_reset();
    test_reset();
    test_tick_div();
    test_msip();
    test_carry();
    test_timer_irq();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_err1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahbl_mtimer.md
AHBL_MTIMER -- requirements
Module: ahbl_mtimer

Interface
REQ-001 Parameter TICK_DIV, default 1: mtime increments once per TICK_DIV clk cycles; legal range 1..256.
REQ-002 Port clk  input  1  single clock; all state is on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port ahbls_hready  input  1  AHB-Lite bus hready.
REQ-005 Port ahbls_hready_resp  output  1  slave hready response.
REQ-006 Port ahbls_hresp  output  1  slave error response.
REQ-007 Port ahbls_haddr  input  32  address; only bits [4:2] are decoded.
REQ-008 Port ahbls_hwrite  input  1  write transfer.
REQ-009 Port ahbls_htrans  input  2  transfer type; bit 1 marks an active transfer.
REQ-010 Port ahbls_hsize  input  3  transfer size.
REQ-011 Port ahbls_hwdata  input  32  write data, valid in the data phase.
REQ-012 Port ahbls_hrdata  output  32  read data, valid in the data phase.
REQ-013 Port soft_irq  output  1  machine software interrupt; drives the CPU's soft_irq.
REQ-014 Port timer_irq  output  1  machine timer interrupt; drives the CPU's timer_irq.

Function
REQ-015 Register map, decoded from haddr[4:2]:
- 0x00 CTRL: bit0 EN.
- 0x04 MSIP: bit0.
- 0x08 MTIME_LO.
- 0x0C MTIME_HI.
- 0x10 MTIMECMP_LO.
- 0x14 MTIMECMP_HI.
- 0x18 and 0x1C: read 0, writes ignored, no error.
REQ-016 An address phase is accepted when ahbls_hready=1 and ahbls_htrans[1]=1; the slave registers haddr[4:2], hwrite and a size-error flag (hsize != 2).
REQ-017 Word transfers complete with zero wait states: ahbls_hready_resp=1 and ahbls_hresp=0 throughout.
REQ-018 Write data is sampled in the data phase; the register updates on the clock edge that ends the data phase.
REQ-019 ahbls_hrdata is combinational from the registered data-phase address; it is 0 outside a read data phase.
REQ-020 A read of MTIME_LO returns the live low word and copies the live high word into a shadow register in the same edge.
REQ-021 A read of MTIME_HI returns the shadow, so a LO-then-HI read pair is atomic; writes to MTIME_HI also update the shadow.
REQ-022 Prescaler: while EN=1, a counter counts 0..TICK_DIV-1 and mtime increments when the counter reaches TICK_DIV-1; while EN=0, both counter and mtime hold.
REQ-023 mtime is a 64-bit counter that wraps from 0xFFFFFFFF_FFFFFFFF to 0; the carry from LO to HI is applied in the same cycle.
REQ-024 A bus write to MTIME_LO or MTIME_HI in the same cycle as an increment wins: the written half takes the write data, and the other half keeps its pre-increment value (no carry applied).
REQ-025 A write to CTRL clears the prescaler counter to 0.
REQ-026 timer_irq is registered as the unsigned 64-bit comparison (mtime >= mtimecmp), re-evaluated every cycle; it is asserted one cycle after the condition becomes true.
REQ-027 soft_irq equals MSIP bit0, registered; it takes effect on the edge that ends the write data phase.
REQ-028 Non-word transfers use a 3-state error FSM: IDLE, ERR1, ERR2.
- Accepted transfer with size error: IDLE -> ERR1.
- ERR1 outputs hready_resp=0, hresp=1, then moves to ERR2.
- ERR2 outputs hready_resp=1, hresp=1, then moves to IDLE.
- The errored transfer has no register side effect and returns hrdata 0.
REQ-029 A new address phase presented during ERR2 (hready=1) is accepted normally; if the master drives IDLE htrans in ERR2, nothing is accepted.
REQ-030 Writes to reserved bits of CTRL and MSIP are ignored; those bits read 0.

Reset
REQ-031 Asynchronous assertion of rst_n=0 forces all of the following:
- ahbls_hready_resp=1, ahbls_hresp=0, ahbls_hrdata=0.
- soft_irq=0, timer_irq=0.
- mtime=0, shadow=0, mtimecmp=0xFFFFFFFF_FFFFFFFF.
- EN=1, MSIP=0, prescaler=0.
- FSM=IDLE, no pending data phase.
REQ-032 Reset asserted mid-transfer or mid-ERR1 aborts the transfer with no register side effect; after release the slave is in IDLE and ready.
REQ-033 No output toggles on the first clock edge after reset release other than as a result of the mtime increment or a bus transfer.

Verification
REQ-034 TICK_DIV=4, EN=1 after reset, 40 idle cycles -> a MTIME_LO read returns 10 (±1 per REQ-022 phase).
REQ-035 Write MTIME_HI=0, MTIME_LO=0xFFFFFFFE, TICK_DIV=1, wait 3 cycles, read LO then HI -> HI=1, LO small, and the pair is consistent via the shadow.
REQ-036 Write MTIMECMP_HI=0, MTIMECMP_LO=20 with mtime=0 -> timer_irq rises exactly one cycle after mtime reaches 20; writing MTIMECMP_HI=1 deasserts it on the next cycle.
REQ-037 Write MSIP=1 -> soft_irq=1 after the data phase; write MSIP=0 -> soft_irq=0; write 0xFFFFFFFE -> soft_irq=0 and a read returns 0.
REQ-038 Byte write (hsize=0) to MTIME_LO -> hready_resp 0 then 1 with hresp=1 for 2 cycles and mtime unaffected; a back-to-back word read issued in ERR2 completes OKAY.
REQ-039 Assert rst_n=0 during ERR1 -> the next cycle shows hready_resp=1, hresp=0, mtimecmp all-ones, timer_irq=0.
